// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths, source enum and writeback entry type
package regfile_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 3;
  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    SRC_LINK = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_NONE = 2'd3
  } src_t;

  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback sources and register-file write port bundle
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                  link_valid;
  logic [DATA_W-1:0]     link_pc;
  logic                  link_ready;

  logic                  load_valid;
  logic [ADDR_W-1:0]     load_addr;
  logic [DATA_W-1:0]     load_data;
  logic                  load_ready;

  logic                  alu_valid;
  logic [ADDR_W-1:0]     alu_addr;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2**ADDR_W-1:0]  pending;
  logic [1:0]            grant_src;

  modport master (
    output link_valid, link_pc, load_valid, load_addr, load_data,
           alu_valid, alu_addr, alu_data,
    input  link_ready, load_ready, alu_ready,
           wr_en, wr_addr, wr_data, pending, grant_src
  );

  modport slave (
    input  link_valid, link_pc, load_valid, load_addr, load_data,
           alu_valid, alu_addr, alu_data,
    output link_ready, load_ready, alu_ready,
           wr_en, wr_addr, wr_data, pending, grant_src
  );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rtl/regfile_write_arbiter_rr.sv - three-way round-robin picker, search starts at rr_ptr
module rr_arbiter3
  import regfile_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [1:0]         winner
);

  logic [1:0] idx;

  always_comb begin
    grant  = '0;
    winner = SRC_NONE;
    idx    = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant == '0 && eligible[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - one-entry buffers per writeback source, ordered RR grant to the write port
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  wb_entry_t          entry_q  [NUM_SRC];
  wb_entry_t          incoming [NUM_SRC];
  logic [NUM_SRC-1:0] older_q  [NUM_SRC];
  logic [NUM_SRC-1:0] older_d  [NUM_SRC];
  logic [1:0]         rr_ptr_q;

  logic [NUM_SRC-1:0] valid_in;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] store;
  logic [NUM_SRC-1:0] stay;
  logic [1:0]         winner;

  always_comb begin
    valid_in = {bus.alu_valid, bus.load_valid, bus.link_valid};

    incoming[0].full = 1'b1;
    incoming[0].addr = LINK_REG;
    incoming[0].data = bus.link_pc + DATA_W'(4);
    incoming[1].full = 1'b1;
    incoming[1].addr = bus.load_addr;
    incoming[1].data = bus.load_data;
    incoming[2].full = 1'b1;
    incoming[2].addr = bus.alu_addr;
    incoming[2].data = bus.alu_data;
  end

  // An entry waits while an older buffered write targets the same register.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = entry_q[i].full;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j != i && entry_q[j].full && older_q[j][i] &&
            entry_q[j].addr == entry_q[i].addr)
          eligible[i] = 1'b0;
      end
    end
  end

  rr_arbiter3 u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .winner   (winner)
  );

  // Writes to r0 complete the handshake but are never buffered.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = !entry_q[i].full || grant[i];
      store[i] = valid_in[i] && ready[i] && (incoming[i].addr != '0);
      stay[i]  = entry_q[i].full && !grant[i];
    end
  end

  // New entries are younger than survivors; same-cycle arrivals order by index.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        older_d[i][j] = 1'b0;
        if (i != j) begin
          if (store[i] && store[j])
            older_d[i][j] = (i < j);
          else if (store[j])
            older_d[i][j] = stay[i];
          else if (!store[i])
            older_d[i][j] = older_q[i][j] && stay[i] && stay[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
      rr_ptr_q <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (store[i])
          entry_q[i] <= incoming[i];
        else if (grant[i])
          entry_q[i].full <= 1'b0;
        older_q[i] <= older_d[i];
      end
      if (grant != '0)
        rr_ptr_q <= rr_next(winner);
    end
  end

  assign bus.link_ready = ready[0];
  assign bus.load_ready = ready[1];
  assign bus.alu_ready  = ready[2];

  always_comb begin
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.grant_src = SRC_NONE;
    if (grant != '0) begin
      bus.wr_en     = 1'b1;
      bus.wr_addr   = entry_q[winner].addr;
      bus.wr_data   = entry_q[winner].data;
      bus.grant_src = winner;
    end
  end

  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (entry_q[i].full)
        bus.pending[entry_q[i].addr] = 1'b1;
    end
    bus.pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
    logic [31:0] pend;
    logic [2:0]  rdy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  logic [31:0] mem_exp [32];
  logic [31:0] mem_obs [32];

  // Reference: each source holds at most one outstanding write tagged with an arrival sequence number.
  bit          m_full [3];
  logic [4:0]  m_addr [3];
  logic [31:0] m_data [3];
  int          m_seq  [3];
  int          seq_ctr = 0;
  int          m_rr = 0;

  function automatic bit m_eligible(int i);
    if (!m_full[i]) return 1'b0;
    for (int j = 0; j < 3; j++)
      if (j != i && m_full[j] && m_addr[j] == m_addr[i] && m_seq[j] < m_seq[i])
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_exp[i] = '0;
      mem_obs[i] = '0;
    end
    for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
  end

  // Model: predicts this cycle's outputs, then advances on the inputs present this cycle.
  initial begin
    exp_t e;
    int w;
    bit        v [3];
    logic [4:0]  a [3];
    logic [31:0] d [3];
    forever begin
      @(negedge clk);
      e.en = 1'b0; e.addr = '0; e.data = '0; e.src = 2'd3; e.pend = '0; e.rdy = 3'b111;
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
        m_rr = 0;
        exp_q.push_back(e);
      end else begin
        w = -1;
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (m_rr + k) % 3;
          if (w < 0 && m_eligible(idx)) w = idx;
        end
        for (int i = 0; i < 3; i++) begin
          if (m_full[i]) e.pend[m_addr[i]] = 1'b1;
          e.rdy[i] = !m_full[i] || (w == i);
        end
        if (w >= 0) begin
          e.en = 1'b1; e.addr = m_addr[w]; e.data = m_data[w]; e.src = 2'(w);
        end
        exp_q.push_back(e);
        if (w >= 0) begin
          mem_exp[m_addr[w]] = m_data[w];
          m_full[w] = 1'b0;
          m_rr = (w + 1) % 3;
        end
        v[0] = bus.link_valid; a[0] = 5'd31;         d[0] = bus.link_pc + 32'd4;
        v[1] = bus.load_valid; a[1] = bus.load_addr; d[1] = bus.load_data;
        v[2] = bus.alu_valid;  a[2] = bus.alu_addr;  d[2] = bus.alu_data;
        for (int i = 0; i < 3; i++) begin
          if (v[i] && e.rdy[i] && a[i] != 5'd0) begin
            m_full[i] = 1'b1; m_addr[i] = a[i]; m_data[i] = d[i]; m_seq[i] = seq_ctr++;
          end
        end
      end
    end
  end

  // Monitor: one expected record per cycle, compared against what the DUT presents.
  initial begin
    exp_t e;
    logic [2:0] rdy;
    forever begin
      @(negedge clk);
      #1;
      cycle++;
      rdy = {bus.alu_ready, bus.load_ready, bus.link_ready};
      if (bus.wr_en === 1'b1) mem_obs[bus.wr_addr] = bus.wr_data;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty at cycle %0d", cycle);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_en !== e.en || bus.wr_addr !== e.addr || bus.wr_data !== e.data ||
            bus.grant_src !== e.src || bus.pending !== e.pend || rdy !== e.rdy) begin
          fails++;
          $display("FAIL cycle_%0d got en=%0b addr=%0d data=%h src=%0d pend=%h rdy=%b expected en=%0b addr=%0d data=%h src=%0d pend=%h rdy=%b",
                   cycle, bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_src, bus.pending, rdy,
                   e.en, e.addr, e.data, e.src, e.pend, e.rdy);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.link_valid = 1'b0;
    bus.load_valid = 1'b0;
    bus.alu_valid  = 1'b0;
  endtask

  task automatic drive(input bit lv, input logic [31:0] pc,
                       input bit dv, input logic [4:0] da, input logic [31:0] dd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
    bus.link_valid = lv; bus.link_pc   = pc;
    bus.load_valid = dv; bus.load_addr = da; bus.load_data = dd;
    bus.alu_valid  = av; bus.alu_addr  = aa; bus.alu_data  = ad;
  endtask

  initial begin
    drive(0, '0, 0, '0, '0, 0, '0, '0);
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_wr_en", 32'(bus.wr_en), 32'd0);
    check("reset_grant_src", 32'(bus.grant_src), 32'd3);
    check("reset_pending", bus.pending, 32'd0);
    check("reset_readys", 32'({bus.alu_ready, bus.load_ready, bus.link_ready}), 32'd7);
    rst_n = 1'b1;
    step();

    drive(0, '0, 0, '0, '0, 1, 5'd5, 32'hDEADBEEF);
    step(); idle();
    repeat (3) step();
    check("alu_r5", mem_obs[5], 32'hDEADBEEF);

    drive(1, 32'h00400010, 0, '0, '0, 0, '0, '0);
    step(); idle();
    repeat (3) step();
    check("link_r31", mem_obs[31], 32'h00400014);

    drive(1, 32'hFFFFFFFC, 0, '0, '0, 0, '0, '0);
    step(); idle();
    repeat (3) step();
    check("link_wrap", mem_obs[31], 32'h00000000);

    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    drive(1, 32'h00001000, 1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
    step(); idle();
    repeat (5) step();
    check("all3_r8", mem_obs[8], 32'h88);
    check("all3_r9", mem_obs[9], 32'h99);

    drive(0, '0, 1, 5'd8, 32'h11, 0, '0, '0);
    step();
    drive(0, '0, 0, '0, '0, 1, 5'd8, 32'h22);
    step(); idle();
    repeat (4) step();
    check("order_r8_seq", mem_obs[8], 32'h22);

    drive(0, '0, 1, 5'd3, 32'h3, 0, '0, '0);
    step(); idle(); step();
    drive(0, '0, 1, 5'd8, 32'h33, 1, 5'd8, 32'h44);
    step(); idle();
    repeat (4) step();
    check("order_r8_same", mem_obs[8], 32'h44);

    drive(0, '0, 0, '0, '0, 1, 5'd0, 32'hFFFFFFFF);
    #1 check("r0_ready", 32'(bus.alu_ready), 32'd1);
    step(); idle();
    repeat (3) step();
    check("r0_untouched", mem_obs[0], 32'd0);

    drive(1, 32'h2000, 1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
    step();
    drive(1, 32'h3000, 1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_pending", bus.pending, 32'd0);
    check("midrst_readys", 32'({bus.alu_ready, bus.load_ready, bus.link_ready}), 32'd7);
    check("midrst_grant_src", 32'(bus.grant_src), 32'd3);
    idle();
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();

    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 9) < 6, $urandom,
            $urandom_range(0, 9) < 6,
            ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)),
            $urandom,
            $urandom_range(0, 9) < 6,
            ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)),
            $urandom);
      step();
    end
    idle();
    repeat (6) step();
    @(negedge clk);
    #3;
    for (int i = 0; i < 32; i++) check($sformatf("regfile_r%0d", i), mem_obs[i], mem_exp[i]);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
